// File: rtl/opamp_array_ctrl.sv
// opamp_array_ctrl: switch controller for NUM_CH on-die opamp channels.
// Each channel drives {MON,FB,INN,INP}. Mode changes are break-before-make
// with DEAD_CYC open cycles. Define OPAMP_ARRAY_SCAN_EN to build the monitor
// scan sequencer; without it the scan inputs are ignored and MON stays open.

// Per-channel switch register: holds the mode and the four switch enables.
module opamp_ch_sw (
    input  logic       clk,
    input  logic       rst,
    input  logic       brk,
    input  logic       load,
    input  logic [1:0] load_mode,
    input  logic       mon_close,
    input  logic       mon_open,
    output logic [1:0] mode,
    output logic [3:0] sw
);
    // {FB,INN,INP}; INP is on ZREF inside the tile in inverting mode
    function automatic logic [2:0] mode_pat(input logic [1:0] m);
        case (m)
            2'b01:   mode_pat = 3'b101;
            2'b10:   mode_pat = 3'b011;
            2'b11:   mode_pat = 3'b010;
            default: mode_pat = 3'b000;
        endcase
    endfunction

    // break opens the signal switches, load applies the new mode after dead time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= 2'b00;
            sw   <= 4'b0000;
        end else begin
            if (brk)
                sw[2:0] <= 3'b000;
            if (load) begin
                mode    <= load_mode;
                sw[2:0] <= mode_pat(load_mode);
            end
            if (mon_open)
                sw[3] <= 1'b0;
            else if (mon_close)
                sw[3] <= 1'b1;
        end
    end
endmodule

module opamp_array_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int DEAD_CYC = 4,
    parameter int DWELL_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_mode,
    input  logic                      scan_start,
    input  logic                      scan_stop,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [4*NUM_CH-1:0]       sw_en,
    output logic                      scan_busy,
    output logic [$clog2(NUM_CH)-1:0] scan_ch,
    output logic                      scan_done
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int DC_W  = $clog2(DEAD_CYC + 1);
    localparam int CNT_W = (DC_W > DWELL_W) ? DC_W : DWELL_W;

`ifdef OPAMP_ARRAY_SCAN_EN
    typedef enum logic [1:0] {IDLE, BREAK, SCAN_BREAK, SCAN_DWELL} state_t;
`else
    typedef enum logic [1:0] {IDLE, BREAK} state_t;
`endif

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [1:0]      mode;
    } cfg_req_t;

    state_t                       state;
    cfg_req_t                     req;
    logic [CNT_W-1:0]             cnt;
    logic                         dead_done;
    logic [NUM_CH-1:0]            brk_vec;
    logic [NUM_CH-1:0]            load_vec;
    logic [NUM_CH-1:0]            mon_close_vec;
    logic                         mon_open_all;
    logic [NUM_CH-1:0][1:0]       mode_q;
    logic [NUM_CH-1:0][3:0]       sw_q;

    assign dead_done = (cnt == CNT_W'(DEAD_CYC - 1));
    assign sw_en     = sw_q;

    // per-channel strobes and switch registers
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign brk_vec[c]  = (state == IDLE) && cfg_valid && (cfg_ch == CH_W'(c));
        assign load_vec[c] = (state == BREAK) && dead_done && (req.ch == CH_W'(c));

        opamp_ch_sw u_ch (
            .clk       (clk),
            .rst       (rst),
            .brk       (brk_vec[c]),
            .load      (load_vec[c]),
            .load_mode (req.mode),
            .mon_close (mon_close_vec[c]),
            .mon_open  (mon_open_all),
            .mode      (mode_q[c]),
            .sw        (sw_q[c])
        );
    end

`ifdef OPAMP_ARRAY_SCAN_EN
    logic [NUM_CH-1:0] ch_en;
    logic              first_found, next_found;
    logic [CH_W-1:0]   first_ch, next_ch;
    logic [DWELL_W-1:0] dwell_q;
    logic [CNT_W-1:0]  dwell_m1;
    logic              dwell_done;

    assign dwell_m1   = CNT_W'(dwell_q) - CNT_W'(1);
    assign dwell_done = (cnt == dwell_m1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_scan
        assign ch_en[c]         = |mode_q[c];
        assign mon_close_vec[c] = (state == SCAN_BREAK) && !scan_stop && dead_done &&
                                  (scan_ch == CH_W'(c));
    end
    // only the selected channel's MON is ever closed, so opening all is safe
    assign mon_open_all = (state == SCAN_DWELL) && (scan_stop || dwell_done);

    // lowest enabled channel, and lowest enabled channel above scan_ch
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_en[c]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(c);
            end
            if (ch_en[c] && (CH_W'(c) > scan_ch)) begin
                next_found = 1'b1;
                next_ch    = CH_W'(c);
            end
        end
    end
`else
    logic unused_scan;
    assign unused_scan   = ^{scan_start, scan_stop, dwell, mode_q};
    assign mon_close_vec = '0;
    assign mon_open_all  = 1'b0;
    assign scan_busy     = 1'b0;
    assign scan_ch       = '0;
    assign scan_done     = 1'b0;
`endif

    // control FSM: config break-before-make and the optional monitor scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req       <= '0;
            cnt       <= '0;
            cfg_ready <= 1'b1;
`ifdef OPAMP_ARRAY_SCAN_EN
            scan_busy <= 1'b0;
            scan_ch   <= '0;
            scan_done <= 1'b0;
            dwell_q   <= '0;
`endif
        end else begin
`ifdef OPAMP_ARRAY_SCAN_EN
            scan_done <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        req.ch    <= cfg_ch;
                        req.mode  <= cfg_mode;
                        cnt       <= '0;
                        cfg_ready <= 1'b0;
                        state     <= BREAK;
                    end
`ifdef OPAMP_ARRAY_SCAN_EN
                    else if (scan_start) begin
                        if (first_found) begin
                            scan_busy <= 1'b1;
                            scan_ch   <= first_ch;
                            dwell_q   <= (dwell == '0) ? DWELL_W'(1) : dwell;
                            cnt       <= '0;
                            cfg_ready <= 1'b0;
                            state     <= SCAN_BREAK;
                        end else begin
                            scan_done <= 1'b1;
                            scan_busy <= 1'b0;
                        end
                    end
`endif
                end
                BREAK: begin
                    if (dead_done) begin
                        cfg_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef OPAMP_ARRAY_SCAN_EN
                SCAN_BREAK: begin
                    if (scan_stop) begin
                        scan_busy <= 1'b0;
                        scan_done <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (dead_done) begin
                        cnt   <= '0;
                        state <= SCAN_DWELL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SCAN_DWELL: begin
                    if (scan_stop) begin
                        scan_busy <= 1'b0;
                        scan_done <= 1'b1;
                        cfg_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (dwell_done) begin
                        if (next_found) begin
                            scan_ch <= next_ch;
                            cnt     <= '0;
                            state   <= SCAN_BREAK;
                        end else begin
                            scan_busy <= 1'b0;
                            scan_done <= 1'b1;
                            cfg_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_opamp_array_ctrl.sv
// Bench for opamp_array_ctrl: table-driven config vectors with a scoreboard
// of applied patterns, plus hand sequences for scan, abort and reset.
module tb_opamp_array_ctrl;
    localparam int NUM_CH  = 4;
    localparam int DC      = 4;
    localparam int DWELL_W = 8;
    localparam int CH_W    = $clog2(NUM_CH);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cfg_valid, cfg_ready;
    logic [CH_W-1:0]       cfg_ch;
    logic [1:0]            cfg_mode;
    logic                  scan_start, scan_stop;
    logic [DWELL_W-1:0]    dwell;
    logic [4*NUM_CH-1:0]   sw_en;
    logic                  scan_busy, scan_done;
    logic [CH_W-1:0]       scan_ch;

    opamp_array_ctrl #(.NUM_CH(NUM_CH), .DEAD_CYC(DC), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .scan_start(scan_start),
        .scan_stop(scan_stop), .dwell(dwell), .sw_en(sw_en),
        .scan_busy(scan_busy), .scan_ch(scan_ch), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; logic [1:0] mode; logic [2:0] pat; } vec_t;
    typedef struct { int ch; logic [2:0] pat; } sb_t;

    int n_cmp = 0;
    int n_err = 0;
    sb_t exp_q[$];
    logic [NUM_CH-1:0][3:0] exp_sw;
    logic [4*NUM_CH-1:0]    pat_mask;
    vec_t vecs[9];
    logic prev_rdy = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] mon_of(input logic [4*NUM_CH-1:0] s);
        logic [NUM_CH-1:0] m;
        for (int c = 0; c < NUM_CH; c++) m[c] = s[4*c+3];
        return m;
    endfunction

    // scoreboard: pop the expected pattern when cfg_ready comes back
    always @(negedge clk) begin
        sb_t e;
        if (!prev_rdy && cfg_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pattern", 32'(sw_en[4*e.ch +: 3]), 32'(e.pat));
        end
        prev_rdy = cfg_ready;
    end

    // one full config: break phase checked every cycle, then the new pattern
    task automatic do_cfg(input int ch, input logic [1:0] mode, input logic [2:0] pat);
        int guard = 0;
        while (!cfg_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("cfg_ready_wait", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_mode  = mode;
        exp_q.push_back('{ch: ch, pat: pat});
        @(negedge clk);
        cfg_valid = 1'b0;
        exp_sw[ch][2:0] = 3'b000;
        chk("brk_open", sw_en, exp_sw);
        chk("brk_ready", cfg_ready, 0);
        chk("brk_nobusy", scan_busy, 0);
        repeat (DC - 1) begin
            @(negedge clk);
            chk("brk_hold", sw_en, exp_sw);
            chk("brk_ready_hold", cfg_ready, 0);
        end
        @(negedge clk);
        exp_sw[ch][2:0] = pat;
        chk("apply_sw", sw_en, exp_sw);
        chk("apply_ready", cfg_ready, 1);
    endtask

`ifdef OPAMP_ARRAY_SCAN_EN
    // expects scan_start to be sampled at the coming edge
    task automatic scan_check(input int d, input logic [NUM_CH-1:0] en);
        int done_t, idx, close, ech;
        logic [NUM_CH-1:0] em;
        @(negedge clk);
        scan_start = 1'b0;
        chk("scan_busy_start", scan_busy, 1);
        chk("scan_ready_start", cfg_ready, 0);
        chk("scan_mon_start", mon_of(sw_en), 0);
        done_t = 0;
        idx = 0;
        for (int c = 0; c < NUM_CH; c++)
            if (en[c]) begin
                close  = DC + idx * (d + DC);
                done_t = close + d;
                idx++;
            end
        for (int t = 1; t <= done_t; t++) begin
            @(negedge clk);
            em  = '0;
            ech = -1;
            idx = 0;
            for (int c = 0; c < NUM_CH; c++)
                if (en[c]) begin
                    close = DC + idx * (d + DC);
                    if (t >= close && t < close + d) begin
                        em[c] = 1'b1;
                        ech   = c;
                    end
                    idx++;
                end
            chk("scan_mon", mon_of(sw_en), em);
            if (ech >= 0) chk("scan_ch", scan_ch, ech);
            chk("scan_pat_kept", sw_en & pat_mask, exp_sw);
            chk("scan_done", scan_done, (t == done_t));
            chk("scan_busy", scan_busy, (t < done_t));
        end
        chk("scan_ready_end", cfg_ready, 1);
        @(negedge clk);
        chk("scan_done_drop", scan_done, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{ch: 2, mode: 2'b01, pat: 3'b101};
        vecs[1] = '{ch: 2, mode: 2'b10, pat: 3'b011};
        vecs[2] = '{ch: 2, mode: 2'b10, pat: 3'b011};
        vecs[3] = '{ch: 0, mode: 2'b11, pat: 3'b010};
        vecs[4] = '{ch: 1, mode: 2'b01, pat: 3'b101};
        vecs[5] = '{ch: 3, mode: 2'b10, pat: 3'b011};
        vecs[6] = '{ch: 1, mode: 2'b00, pat: 3'b000};
        vecs[7] = '{ch: 3, mode: 2'b11, pat: 3'b010};
        vecs[8] = '{ch: 2, mode: 2'b00, pat: 3'b000};
        for (int c = 0; c < NUM_CH; c++) pat_mask[4*c +: 4] = 4'b0111;
        exp_sw = '0;

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = 2'b00;
        scan_start = 1'b0; scan_stop = 1'b0; dwell = 8'd3;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sw", sw_en, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", scan_busy, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_scan_ch", scan_ch, 0);

        // config table, back to back
        for (int i = 0; i < 9; i++) do_cfg(vecs[i].ch, vecs[i].mode, vecs[i].pat);

        // config wins over scan_start; ch0 and ch3 remain enabled
        dwell = 8'd3;
        scan_start = 1'b1;
        do_cfg(1, 2'b00, 3'b000);
`ifdef OPAMP_ARRAY_SCAN_EN
        scan_check(3, 4'b1001);

        dwell = 8'd0;
        scan_start = 1'b1;
        scan_check(1, 4'b1001);

        // abort in the middle of the first dwell
        dwell = 8'd5;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        repeat (DC) @(negedge clk);
        chk("stop_mon_closed", mon_of(sw_en), 4'b0001);
        @(negedge clk);
        scan_stop = 1'b1;
        @(negedge clk);
        scan_stop = 1'b0;
        chk("stop_mon_open", mon_of(sw_en), 0);
        chk("stop_done", scan_done, 1);
        chk("stop_busy", scan_busy, 0);
        chk("stop_ready", cfg_ready, 1);
        chk("stop_pat", sw_en, exp_sw);
        @(negedge clk);
        chk("stop_done_drop", scan_done, 0);

        // nothing enabled: immediate done, no switch change
        do_cfg(0, 2'b00, 3'b000);
        do_cfg(3, 2'b00, 3'b000);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        chk("empty_done", scan_done, 1);
        chk("empty_busy", scan_busy, 0);
        chk("empty_ready", cfg_ready, 1);
        chk("empty_sw", sw_en, exp_sw);
        @(negedge clk);
        chk("empty_done_drop", scan_done, 0);
        chk("empty_sw_hold", sw_en, exp_sw);
`else
        repeat (3) begin
            @(negedge clk);
            chk("noscan_busy", scan_busy, 0);
            chk("noscan_done", scan_done, 0);
            chk("noscan_ready", cfg_ready, 1);
            chk("noscan_sw", sw_en, exp_sw);
        end
        scan_start = 1'b0;
`endif

        // reset in the middle of a break discards the pending mode
        do_cfg(1, 2'b11, 3'b010);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(2);
        cfg_mode  = 2'b01;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("rb_ready_low", cfg_ready, 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        #1;
        exp_sw = '0;
        chk("rb_sw_now", sw_en, 0);
        chk("rb_ready_now", cfg_ready, 1);
        chk("rb_busy_now", scan_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (DC + 2) @(negedge clk);
        chk("rb_sw_after", sw_en, 0);
        chk("rb_ready_after", cfg_ready, 1);
        chk("rb_done_after", scan_done, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/opamp_array_ctrl.md
# opamp_array_ctrl

Digital switch controller for an array of NUM_CH on-die opamp channels on the analog tile. Each channel gets its own switch pattern: input, feedback and monitor-bus switches. Pattern changes use break-before-make with a programmable dead time. An optional scan sequencer routes each enabled channel in turn onto the shared monitor bus. The block sits between the tile's digital pins (config port) and the analog switch enables of the opamp instances.

## Interface
Parameters:
- NUM_CH, 4: number of opamp channels (2..8).
- DEAD_CYC, 4: break-before-make open time in clk cycles (>=1).
- DWELL_W, 8: width of the scan dwell count.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; high only in IDLE.
- cfg_ch  in  $clog2(NUM_CH)  target channel.
- cfg_mode  in  2  00 off, 01 follower, 10 comparator, 11 inverting.
- scan_start  in  1  level request, sampled in IDLE only.
- scan_stop  in  1  abort scan.
- dwell  in  DWELL_W  monitor dwell cycles; latched at scan start.
- sw_en  out  4*NUM_CH  per channel {MON,FB,INN,INP} at bits [4c+3:4c].
- scan_busy  out  1  scan in progress.
- scan_ch  out  $clog2(NUM_CH)  channel on monitor bus; valid while its MON is closed.
- scan_done  out  1  one-cycle pulse at scan end or abort.

## Operation
- Mode to {FB,INN,INP}: off 000, follower 101, comparator 011, inverting 010. INP is tied to ZREF internally in inverting mode.
- FSM states are IDLE, BREAK, SCAN_BREAK, SCAN_DWELL, and SCAN_DWELL is decided by the scan feature.
- IDLE:
  - cfg_ready=1.
  - cfg_valid has priority over scan_start.
  - scan_start is sampled only when cfg_valid=0.
- Config handshake: a transfer occurs when cfg_valid and cfg_ready are both high.
  - The target channel's INP, INN and FB open.
  - FSM moves to BREAK.
- BREAK:
  - Counts DEAD_CYC cycles.
  - Then the channel's mode register takes cfg_mode and its pattern is applied. FSM returns to IDLE.
  - Other channels are unaffected throughout.
- Re-config to the same mode still performs the full break.
- scan_start in IDLE:
  - Latch max(dwell,1).
  - Set scan_busy.
  - Select the lowest channel whose mode is not off.
  - If no channel is enabled: pulse scan_done, clear scan_busy and stay in IDLE. No switch changes.
- SCAN_BREAK: all MON bits open for DEAD_CYC cycles, then SCAN_DWELL.
- SCAN_DWELL:
  - MON of scan_ch is closed for the latched dwell count.
  - Then MON opens and the next higher enabled channel is selected via SCAN_BREAK.
  - If no enabled channel is left: scan_done pulses and FSM returns to IDLE.
  - Single pass, no wrap.
- scan_stop in any scan state: on the next edge MON opens, scan_done pulses and FSM returns to IDLE.
- INP/INN/FB patterns are never altered by scanning.
- At most one MON bit is high at any time.

## Timing
- Reset (async) values:
  - sw_en=0 and all modes off.
  - scan_busy=0, scan_done=0, scan_ch=0.
  - cfg_ready=1, FSM in IDLE.
- Config accepted at edge N:
  - The channel's pattern bits are 0 after edge N.
  - The new pattern is visible after edge N+DEAD_CYC.
  - cfg_ready=0 from after edge N until after edge N+DEAD_CYC.
  - Back-to-back configs are therefore DEAD_CYC+1 cycles apart.
- Scan started at edge M:
  - First MON closes after edge M+DEAD_CYC.
  - It stays closed for D cycles.
  - The next MON closes DEAD_CYC cycles after the previous one opens.
- scan_done is registered, high for exactly one cycle, in the cycle FSM re-enters IDLE.
- All outputs are registered. No combinational path from inputs to sw_en.
- Reset mid-BREAK or mid-scan: every output returns to its reset value immediately and the pending config is discarded.

## Configuration
- OPAMP_ARRAY_SCAN_EN defined: scan sequencer compiled in as above.
- Undefined:
  - scan_start, scan_stop and dwell are ignored.
  - scan_busy, scan_done, scan_ch and all MON bits are tied 0.
  - SCAN states are absent.
  - Config behaviour is identical.

## Test plan
- Reset then idle: sw_en=0, cfg_ready=1, scan_busy=0.
- Config ch2 follower (NUM_CH=4, DEAD_CYC=4):
  - sw_en[11:8]=0000 for 4 cycles, then 0101.
  - cfg_ready low for 4 cycles.
  - Then reconfigure ch2 to comparator: 0000 for 4 cycles, then 0011.
- Simultaneous cfg_valid and scan_start in IDLE: config accepted, no scan. Scan begins after the config completes if scan_start is still held.
- Scan with ch0 and ch3 enabled, dwell=3:
  - MON0 closed for 3 cycles.
  - 4 cycles with all MON open.
  - MON3 closed for 3 cycles.
  - scan_done pulse; MON never two-hot.
- scan_start with all channels off: scan_done pulses next cycle and sw_en stays unchanged. Also dwell=0 yields a 1-cycle dwell.
- scan_stop mid-dwell and async rst mid-BREAK:
  - scan_stop: MON opens next edge and scan_done pulses.
  - rst: all outputs reset and the pending mode is not applied.
